// File: rtl/microcode_sequencer.sv
// Next-state sequencer for the microprogrammed control unit.
// Holds the control-store address and decodes the ROM word's next-state fields.
//
// Ports:
//   clk        in   1  rising-edge clock
//   reset      in   1  asynchronous active-high reset
//   enc_state  in   7  dispatch target from the instruction encoder
//   ns         in   3  next-state mode of the current ROM word
//   cr         in   7  literal target of the current ROM word
//   inv        in   1  invert the selected condition
//   cond_sel   in   2  00 moc, 01 cond_pass, 10 irq, 11 constant 1
//   moc        in   1  memory operation complete
//   cond_pass  in   1  condition-field evaluation result
//   irq        in   1  interrupt pending (level)
//   state      out  7  current microstore state (registered)
//   waiting    out  1  current word is WAIT_MOC and moc is low
//   fault      out  1  one-cycle pulse on any sequencing fault
//   fault_code out  2  01 timeout, 10 return-empty, 11 call-overflow (sticky)
module microcode_sequencer #(
    parameter logic [6:0]  FETCH_ADDR  = 7'd1,
    parameter logic [6:0]  RESET_ADDR  = 7'd0,
    parameter logic [6:0]  FAULT_ADDR  = 7'd127,
    parameter int unsigned MOC_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] enc_state,
    input  logic [2:0] ns,
    input  logic [6:0] cr,
    input  logic       inv,
    input  logic [1:0] cond_sel,
    input  logic       moc,
    input  logic       cond_pass,
    input  logic       irq,
    output logic [6:0] state,
    output logic       waiting,
    output logic       fault,
    output logic [1:0] fault_code
);

    typedef enum logic [2:0] {
        NS_INC      = 3'b000,
        NS_JUMP     = 3'b001,
        NS_DISPATCH = 3'b010,
        NS_CBRANCH  = 3'b011,
        NS_WAIT_MOC = 3'b100,
        NS_RETURN   = 3'b101,
        NS_CALL     = 3'b110,
        NS_FETCH    = 3'b111
    } ns_mode_e;

    typedef enum logic [1:0] {
        FC_NONE      = 2'b00,
        FC_TIMEOUT   = 2'b01,
        FC_RET_EMPTY = 2'b10,
        FC_CALL_OVF  = 2'b11
    } fault_code_e;

    // Last count value before the watchdog fires.
    localparam logic [7:0] WAIT_LIMIT = 8'(MOC_TIMEOUT - 1);

    ns_mode_e   mode;
    logic [6:0] inc;
    logic       cond_raw;
    logic       cond;

    logic [6:0] ret_reg;
    logic       ret_valid;
    logic [7:0] wait_cnt;

    logic [6:0] state_next;
    logic [6:0] ret_next;
    logic       ret_valid_next;
    logic [7:0] wait_next;
    logic       fault_next;
    logic [1:0] code_next;

    assign mode    = ns_mode_e'(ns);
    // 7-bit add wraps 127 -> 0 on its own.
    assign inc     = state + 7'd1;
    assign waiting = (mode == NS_WAIT_MOC) & ~moc;

    always_comb begin
        cond_raw = 1'b1;
        unique case (cond_sel)
            2'b00: cond_raw = moc;
            2'b01: cond_raw = cond_pass;
            2'b10: cond_raw = irq;
            2'b11: cond_raw = 1'b1;
        endcase
        cond = cond_raw ^ inv;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= RESET_ADDR;
            ret_reg    <= '0;
            ret_valid  <= 1'b0;
            wait_cnt   <= '0;
            fault      <= 1'b0;
            fault_code <= FC_NONE;
        end else begin
            state      <= state_next;
            ret_reg    <= ret_next;
            ret_valid  <= ret_valid_next;
            wait_cnt   <= wait_next;
            fault      <= fault_next;
            fault_code <= code_next;
        end
    end

    always_comb begin
        state_next     = inc;
        ret_next       = ret_reg;
        ret_valid_next = ret_valid;
        // Counter only survives consecutive WAIT_MOC cycles.
        wait_next      = '0;
        fault_next     = 1'b0;
        code_next      = fault_code;

        unique case (mode)
            NS_INC: begin
                state_next = inc;
            end
            NS_JUMP: begin
                state_next = cr;
            end
            NS_DISPATCH: begin
                state_next = enc_state;
            end
            NS_CBRANCH: begin
                state_next = cond ? cr : inc;
            end
            NS_WAIT_MOC: begin
                // moc on the last allowed cycle still wins.
                if (moc) begin
                    state_next = inc;
                end else if (wait_cnt < WAIT_LIMIT) begin
                    state_next = state;
                    wait_next  = wait_cnt + 8'd1;
                end else begin
                    state_next = FAULT_ADDR;
                    fault_next = 1'b1;
                    code_next  = FC_TIMEOUT;
                end
            end
            NS_RETURN: begin
                if (ret_valid) begin
                    state_next     = ret_reg;
                    ret_valid_next = 1'b0;
                end else begin
                    state_next = FETCH_ADDR;
                    fault_next = 1'b1;
                    code_next  = FC_RET_EMPTY;
                end
            end
            NS_CALL: begin
                state_next = cr;
                // Single-entry stack: an overflow keeps the older link.
                if (ret_valid) begin
                    fault_next = 1'b1;
                    code_next  = FC_CALL_OVF;
                end else begin
                    ret_next       = inc;
                    ret_valid_next = 1'b1;
                end
            end
            NS_FETCH: begin
                state_next = irq ? cr : FETCH_ADDR;
            end
        endcase
    end

endmodule

// File: tb/tb_microcode_sequencer.sv
// Scoreboard bench for microcode_sequencer.
// Driver plays the control-store ROM; a monitor checks every clock edge.
module tb_microcode_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] enc_state = '0;
    logic [2:0] ns = '0;
    logic [6:0] cr = '0;
    logic       inv = 1'b0;
    logic [1:0] cond_sel = '0;
    logic       moc = 1'b0;
    logic       cond_pass = 1'b0;
    logic       irq = 1'b0;
    logic [6:0] state;
    logic       waiting;
    logic       fault;
    logic [1:0] fault_code;

    microcode_sequencer #(
        .FETCH_ADDR(7'd1),
        .RESET_ADDR(7'd0),
        .FAULT_ADDR(7'd127),
        .MOC_TIMEOUT(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enc_state(enc_state),
        .ns(ns),
        .cr(cr),
        .inv(inv),
        .cond_sel(cond_sel),
        .moc(moc),
        .cond_pass(cond_pass),
        .irq(irq),
        .state(state),
        .waiting(waiting),
        .fault(fault),
        .fault_code(fault_code)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0] st;
        logic       f;
        logic [1:0] code;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_state;
    int m_ret;
    bit m_rv;
    int m_wait;
    int m_code;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_ret = 0;
        m_rv = 0;
        m_wait = 0;
        m_code = 0;
    endtask

    // Drive one ROM word at a negedge, predict the edge, then advance.
    task automatic step(input logic [2:0] n, input logic [6:0] c_r,
                        input logic iv, input logic [1:0] cs,
                        input logic m, input logic cp, input logic iq,
                        input logic [6:0] en);
        int   nxt;
        int   inc;
        bit   sel;
        bit   c;
        bit   f;
        exp_t e;
        ns = n;
        cr = c_r;
        inv = iv;
        cond_sel = cs;
        moc = m;
        cond_pass = cp;
        irq = iq;
        enc_state = en;
        #1;
        chk("waiting", 32'(waiting), 32'(n == 3'd4 && !m));
        inc = (m_state + 1) % 128;
        case (cs)
            2'd0: sel = m;
            2'd1: sel = cp;
            2'd2: sel = iq;
            default: sel = 1'b1;
        endcase
        c = sel ^ iv;
        f = 0;
        nxt = inc;
        case (n)
            3'd0: nxt = inc;
            3'd1: nxt = int'(c_r);
            3'd2: nxt = int'(en);
            3'd3: nxt = c ? int'(c_r) : inc;
            3'd4: begin
                if (m) begin
                    nxt = inc;
                    m_wait = 0;
                end else if (m_wait < 15) begin
                    nxt = m_state;
                    m_wait++;
                end else begin
                    nxt = 127;
                    f = 1;
                    m_code = 1;
                    m_wait = 0;
                end
            end
            3'd5: begin
                if (m_rv) begin
                    nxt = m_ret;
                    m_rv = 0;
                end else begin
                    nxt = 1;
                    f = 1;
                    m_code = 2;
                end
            end
            3'd6: begin
                nxt = int'(c_r);
                if (m_rv) begin
                    f = 1;
                    m_code = 3;
                end else begin
                    m_ret = inc;
                    m_rv = 1;
                end
            end
            default: nxt = iq ? int'(c_r) : 1;
        endcase
        if (n != 3'd4) m_wait = 0;
        m_state = nxt;
        e.st = 7'(nxt);
        e.f = f;
        e.code = 2'(m_code);
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        #1;
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_fault", 32'(fault), 32'd0);
        chk("reset_code", 32'(fault_code), 32'd0);
    endtask

    // Monitor: every non-reset edge consumes one prediction.
    always @(posedge clk) begin
        if (!reset) begin
            #1;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                chk("state", 32'(state), 32'(mon_e.st));
                chk("fault", 32'(fault), 32'(mon_e.f));
                chk("fault_code", 32'(fault_code), 32'(mon_e.code));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        do_reset();

        // Increment and dispatch
        repeat (3) step(3'd0, 7'd0, 0, 2'd0, 1, 0, 0, 7'd0);
        step(3'd2, 7'd0, 0, 2'd0, 1, 0, 0, 7'b0000100);
        step(3'd2, 7'd0, 0, 2'd0, 1, 0, 0, 7'b1010000);

        // Conditional branch, both polarities, then wrap at 127
        step(3'd3, 7'd40, 0, 2'd1, 1, 1, 0, 7'd0);
        step(3'd3, 7'd40, 1, 2'd1, 1, 1, 0, 7'd0);
        step(3'd1, 7'd127, 0, 2'd0, 1, 0, 0, 7'd0);
        step(3'd0, 7'd0, 0, 2'd0, 1, 0, 0, 7'd0);

        // Memory wait: short wait, timeout, moc on the timeout cycle
        repeat (3) step(3'd4, 7'd0, 0, 2'd0, 0, 0, 0, 7'd0);
        step(3'd4, 7'd0, 0, 2'd0, 1, 0, 0, 7'd0);
        repeat (16) step(3'd4, 7'd0, 0, 2'd0, 0, 0, 0, 7'd0);
        step(3'd0, 7'd0, 0, 2'd0, 1, 0, 0, 7'd0);
        repeat (15) step(3'd4, 7'd0, 0, 2'd0, 0, 0, 0, 7'd0);
        step(3'd4, 7'd0, 0, 2'd0, 1, 0, 0, 7'd0);

        // Call / return, including both stack faults
        step(3'd1, 7'd9, 0, 2'd0, 1, 0, 0, 7'd0);
        step(3'd6, 7'd20, 0, 2'd0, 1, 0, 0, 7'd0);
        step(3'd5, 7'd0, 0, 2'd0, 1, 0, 0, 7'd0);
        step(3'd5, 7'd0, 0, 2'd0, 1, 0, 0, 7'd0);
        step(3'd6, 7'd30, 0, 2'd0, 1, 0, 0, 7'd0);
        step(3'd6, 7'd50, 0, 2'd0, 1, 0, 0, 7'd0);
        step(3'd5, 7'd0, 0, 2'd0, 1, 0, 0, 7'd0);

        // Reset during the 5th WAIT_MOC cycle
        repeat (4) step(3'd4, 7'd0, 0, 2'd0, 0, 0, 0, 7'd0);
        ns = 3'd4;
        moc = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("midwait_state", 32'(state), 32'd0);
        chk("midwait_fault", 32'(fault), 32'd0);
        chk("midwait_code", 32'(fault_code), 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        // A fresh counter must tolerate 15 idle cycles
        repeat (15) step(3'd4, 7'd0, 0, 2'd0, 0, 0, 0, 7'd0);
        step(3'd4, 7'd0, 0, 2'd0, 1, 0, 0, 7'd0);

        // Fetch with and without interrupt
        step(3'd7, 7'd24, 0, 2'd0, 1, 0, 1, 7'd0);
        step(3'd7, 7'd24, 0, 2'd0, 1, 0, 0, 7'd0);

        // Randomized ROM words
        for (int i = 0; i < 600; i++) begin
            step(3'($urandom_range(0, 7)), 7'($urandom_range(0, 127)),
                 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)));
        end

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
